iterative_alu: RTL and testbench

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_iter_core.sv | 45 ++++
 rtl/iterative_alu.sv | 125 ++++++++++++
 tb/tb_iterative_alu.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and flag bit positions shared by iterative_alu and alu_iter_core
package alu_pkg;
  typedef enum logic [4:0] {
    OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3, OP_OR = 5'd4,
    OP_NEG = 5'd5, OP_XOR = 5'd6, OP_COMP = 5'd7, OP_LSR = 5'd8, OP_ASR = 5'd9,
    OP_LSL = 5'd10, OP_ROR = 5'd11, OP_ROL = 5'd12, OP_MOVE = 5'd13, OP_PASSB = 5'd14,
    OP_MUL = 5'd16, OP_DIV = 5'd17
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;
  localparam int FLG_DZ = 4;
  localparam int FLG_INR = 5;
  localparam int FLG_W = 6;
endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: one-bit-per-cycle shift-add multiplier / restoring divider (divider only with ITERATIVE_ALU_DIV_EN); ports clk, load, step, div, a, b -> nxt_hi, nxt_lo, last
module alu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc, q, m;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum;
  assign last = cnt == CW'(WIDTH - 1);
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
`ifdef ITERATIVE_ALU_DIV_EN
  logic [WIDTH:0] shl, dif;
  assign shl = {acc, q[WIDTH-1]};
  assign dif = shl - {1'b0, m};
  assign nxt_hi = div ? (dif[WIDTH] ? shl[WIDTH-1:0] : dif[WIDTH-1:0]) : sum[WIDTH:1];
  assign nxt_lo = div ? {q[WIDTH-2:0], ~dif[WIDTH]} : {sum[0], q[WIDTH-1:1]};
`else
  logic unused_div;
  assign unused_div = div;
  assign nxt_hi = sum[WIDTH:1];
  assign nxt_lo = {sum[0], q[WIDTH-1:1]};
`endif
  always_ff @(posedge clk) begin
    if (load) begin
      acc <= '0;
      q <= a;
      m <= b;
      cnt <= '0;
    end else if (step) begin
      acc <= nxt_hi;
      q <= nxt_lo;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle ALU plus iterative MUL/DIV (DIV only with ITERATIVE_ALU_DIV_EN); Start/Op/RA/RB/CarryIn/NopFlag in, Busy/Done/RZ/RZHi/condition flags out
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [4:0]       Op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic             CarryIn,
  input  logic             NopFlag,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RZ,
  output logic [WIDTH-1:0] RZHi,
  output logic             ZeroFlag,
  output logic             NegativeFlag,
  output logic             OverflowFlag,
  output logic             CarryFlag,
  output logic             DivZeroFlag,
  output logic             InrFlag
);
  state_e state, state_nxt;
  logic [FLG_W-1:0] flags, f_nxt;
  logic nop_q, div_q, accept, long_op, ld_res, upd, last;
  logic c_n, v_n, dz_n, inr_n;
  logic [WIDTH-1:0] core_hi, core_lo, res, res_hi;
  logic [WIDTH:0] add_w, sub_w;
  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(Clock), .load(accept), .step(state == RUN), .div(div_q),
    .a(RA), .b(RB), .nxt_hi(core_hi), .nxt_lo(core_lo), .last(last)
  );
  assign accept = Start && state == IDLE;
`ifdef ITERATIVE_ALU_DIV_EN
  assign long_op = Op == OP_MUL || (Op == OP_DIV && RB != '0);
`else
  assign long_op = Op == OP_MUL;
`endif
  assign ld_res = (accept && !long_op) || (state == RUN && last);
  assign upd = state == RUN ? !nop_q : !NopFlag && Op != OP_NOP;
  assign Busy = state == RUN;
  assign Done = state == DONE;
  assign {InrFlag, DivZeroFlag, CarryFlag, OverflowFlag, NegativeFlag, ZeroFlag} =
    {flags[FLG_INR], flags[FLG_DZ], flags[FLG_C], flags[FLG_V], flags[FLG_N], flags[FLG_Z]};
  always_comb
    state_nxt = state == IDLE ? (accept ? (long_op ? RUN : DONE) : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    add_w = {1'b0, RA} + {1'b0, RB};
    sub_w = {1'b0, RA} - {1'b0, RB};
    res = '0;
    res_hi = '0;
    c_n = flags[FLG_C];
    v_n = flags[FLG_V];
    dz_n = 1'b0;
    inr_n = 1'b0;
    if (state == RUN) begin
      res = core_lo;
      res_hi = core_hi;
      c_n = div_q ? flags[FLG_C] : 1'b0;
      v_n = div_q ? flags[FLG_V] : core_hi != '0;
    end else begin
      case (Op)
        OP_NOP, OP_MUL: ;
        OP_ADD: begin
          res = add_w[WIDTH-1:0];
          c_n = add_w[WIDTH];
          v_n = RA[WIDTH-1] == RB[WIDTH-1] && res[WIDTH-1] != RA[WIDTH-1];
        end
        OP_SUB: begin
          res = sub_w[WIDTH-1:0];
          c_n = sub_w[WIDTH];
          v_n = RA[WIDTH-1] != RB[WIDTH-1] && res[WIDTH-1] != RA[WIDTH-1];
        end
        OP_AND: begin res = RA & RB; v_n = 1'b0; end
        OP_OR: begin res = RA | RB; v_n = 1'b0; end
        OP_XOR: begin res = RA ^ RB; v_n = 1'b0; end
        OP_COMP: begin res = ~RA; v_n = 1'b0; end
        OP_NEG: res = -RA;
        OP_LSR: begin res = RA >> 1; c_n = RA[0]; end
        OP_ASR: begin res = $signed(RA) >>> 1; c_n = RA[0]; end
        OP_LSL: begin res = RA << 1; c_n = RA[WIDTH-1]; end
        OP_ROR: begin res = {CarryIn, RA[WIDTH-1:1]}; c_n = RA[0]; end
        OP_ROL: begin res = {RA[WIDTH-2:0], CarryIn}; c_n = RA[WIDTH-1]; end
        OP_MOVE: begin res = RA; v_n = 1'b0; end
        OP_PASSB: begin res = RB; v_n = 1'b0; end
`ifdef ITERATIVE_ALU_DIV_EN
        OP_DIV: begin res = '1; res_hi = RA; dz_n = 1'b1; end
`endif
        default: inr_n = 1'b1;
      endcase
    end
    f_nxt = '0;
    f_nxt[FLG_Z] = res == '0;
    f_nxt[FLG_N] = res[WIDTH-1];
    f_nxt[FLG_V] = v_n;
    f_nxt[FLG_C] = c_n;
    f_nxt[FLG_DZ] = dz_n;
    f_nxt[FLG_INR] = inr_n;
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      RZ <= '0;
      RZHi <= '0;
      flags <= '0;
      nop_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        nop_q <= NopFlag;
        div_q <= Op == OP_DIV;
      end
      if (ld_res) begin
        RZ <= res;
        RZHi <= res_hi;
        if (upd) flags <= f_nxt;
      end
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: randomized and directed check of iterative_alu (WIDTH=32) against an arithmetic reference model
module tb_iterative_alu;
  logic Clock = 1'b0, Resetn = 1'b0, Start = 1'b0, CarryIn = 1'b0, NopFlag = 1'b0;
  logic [4:0] Op = '0;
  logic [31:0] RA = '0, RB = '0;
  logic Busy, Done, ZeroFlag, NegativeFlag, OverflowFlag, CarryFlag, DivZeroFlag, InrFlag;
  logic [31:0] RZ, RZHi;
  logic [5:0] dflags;
  int tests = 0, fails = 0;
  logic m_z = 0, m_n = 0, m_v = 0, m_c = 0, m_dz = 0, m_inr = 0;
  logic [31:0] e_rz, e_hi;
  int e_lat;
  logic [4:0] valid_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd17};
  iterative_alu #(.WIDTH(32)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Op(Op), .RA(RA), .RB(RB),
    .CarryIn(CarryIn), .NopFlag(NopFlag), .Busy(Busy), .Done(Done), .RZ(RZ), .RZHi(RZHi),
    .ZeroFlag(ZeroFlag), .NegativeFlag(NegativeFlag), .OverflowFlag(OverflowFlag),
    .CarryFlag(CarryFlag), .DivZeroFlag(DivZeroFlag), .InrFlag(InrFlag)
  );
  assign dflags = {InrFlag, DivZeroFlag, CarryFlag, OverflowFlag, NegativeFlag, ZeroFlag};
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic nop);
    logic [63:0] w;
    longint s;
    logic [31:0] r, h;
    logic c, v, dz, inr, upd;
    r = '0; h = '0; c = m_c; v = m_v; dz = 0; inr = 0; upd = 1; e_lat = 1;
    case (op)
      0: upd = 0;
      1: begin
        w = {32'b0, a} + {32'b0, b}; r = w[31:0]; c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      2: begin
        r = a - b; c = a < b;
        s = longint'($signed(a)) - longint'($signed(b));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      3: begin r = a & b; v = 0; end
      4: begin r = a | b; v = 0; end
      5: r = 32'd0 - a;
      6: begin r = a ^ b; v = 0; end
      7: begin r = ~a; v = 0; end
      8: begin r = a / 2; c = a[0]; end
      9: begin r = $signed(a) >>> 1; c = a[0]; end
      10: begin r = a * 2; c = a[31]; end
      11: begin r = {cin, a[31:1]}; c = a[0]; end
      12: begin r = {a[30:0], cin}; c = a[31]; end
      13: begin r = a; v = 0; end
      14: begin r = b; v = 0; end
      16: begin
        w = {32'b0, a} * {32'b0, b}; r = w[31:0]; h = w[63:32];
        v = h != 0; c = 0; e_lat = 33;
      end
`ifdef ITERATIVE_ALU_DIV_EN
      17: if (b == 0) begin r = '1; h = a; dz = 1; end
          else begin r = a / b; h = a % b; e_lat = 33; end
`endif
      default: inr = 1;
    endcase
    e_rz = r; e_hi = h;
    if (upd && !nop) begin
      m_z = r == 0; m_n = r[31]; m_c = c; m_v = v; m_dz = dz; m_inr = inr;
    end
  endtask
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic nop, input int poke);
    int n;
    logic seen;
    model(op, a, b, cin, nop);
    @(negedge Clock);
    Op = op; RA = a; RB = b; CarryIn = cin; NopFlag = nop; Start = 1;
    @(posedge Clock);
    #1;
    Start = 0; Op = 5'($urandom); RA = $urandom; RB = $urandom; CarryIn = 1'($urandom); NopFlag = 1'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge Clock);
      n++;
      Start = n == poke;
      if (n == 1) check($sformatf("busy op%0d", op), Busy, e_lat > 1);
      seen = Done;
    end
    check($sformatf("latency op%0d", op), seen ? n : 0, e_lat);
    check($sformatf("rz op%0d a=%0h b=%0h", op, a, b), RZ, e_rz);
    check($sformatf("rzhi op%0d a=%0h b=%0h", op, a, b), RZHi, e_hi);
    check($sformatf("flags op%0d nop=%0d", op, nop), dflags, {m_inr, m_dz, m_c, m_v, m_n, m_z});
    Start = 1; Op = 5'd1; RA = $urandom;
    @(negedge Clock);
    Start = 0;
    check("done_pulse", Done, 0);
    @(negedge Clock);
    check("start_in_done_not_queued", Done, 0);
    check("rz_hold", RZ, e_rz);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [4:0] op;
    logic [31:0] a, b;
    logic quiet;
    Start = 1; Op = 5'd1; RA = 1; RB = 1;
    repeat (3) @(negedge Clock);
    check("rst_rz", RZ, 0);
    check("rst_rzhi", RZHi, 0);
    check("rst_busy_done", {Busy, Done}, 0);
    check("rst_flags", dflags, 0);
    Resetn = 1; Start = 0;
    @(negedge Clock);
    check("no_accept_in_reset", Done, 0);
    run_op(5'd1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    run_op(5'd2, 32'h8000_0000, 32'h1, 0, 0, 0);
    run_op(5'd12, 32'h8000_0000, 32'h0, 1, 0, 0);
    run_op(5'd16, 32'h0001_0000, 32'h0001_0000, 0, 0, 5);
    run_op(5'd17, 32'd100, 32'd7, 0, 0, 0);
    run_op(5'd17, 32'd5, 32'd0, 0, 0, 0);
    @(negedge Clock);
    Op = 5'd16; RA = 32'h1234_5678; RB = 32'h9ABC_DEF0; Start = 1;
    @(posedge Clock);
    #1 Start = 0;
    repeat (9) @(negedge Clock);
    Resetn = 0;
    @(negedge Clock);
    Resetn = 1;
    check("abort_rz", RZ, 0);
    check("abort_rzhi", RZHi, 0);
    check("abort_busy_done", {Busy, Done}, 0);
    check("abort_flags", dflags, 0);
    m_z = 0; m_n = 0; m_v = 0; m_c = 0; m_dz = 0; m_inr = 0;
    quiet = 1;
    repeat (40) begin
      @(negedge Clock);
      if (Done) quiet = 0;
    end
    check("abort_no_done", quiet, 1);
    run_op(5'd1, 32'd2, 32'd3, 0, 0, 0);
    run_op(5'd31, 32'd9, 32'd9, 0, 0, 0);
    run_op(5'd1, 32'd1, 32'd1, 0, 0, 0);
    run_op(5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0);
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : valid_ops[$urandom_range(0, 16)];
      a = pick();
      b = pick();
      if (op == 5'd17 && $urandom_range(0, 4) == 0) b = 0;
      run_op(op, a, b, 1'($urandom), $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) ? $urandom_range(1, 20) : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
